// File: rtl/bcd_serial_conv.sv
// ---------------------------------------------------------------------------
// bcd_serial_conv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock)
// feeding the seven-segment display decoder.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   one-cycle conversion request, honoured only when idle
//   valor_in  in   WIDTH-bit word, captured on the accepting edge
//   bcd       out  packed BCD, digit 0 (units) in bcd[3:0]
//   neg       out  captured value was negative
//   ovf       out  magnitude does not fit in OUT_DIGITS digits
//   blank     out  per-digit leading-zero suppression mask (bit 0 never set)
//   busy      out  conversion in progress or result being presented
//   done      out  one-cycle pulse, outputs updated
// ---------------------------------------------------------------------------
module bcd_serial_conv #(
    parameter int WIDTH      = 32,
    parameter int INT_DIGITS = 10,
    parameter int OUT_DIGITS = 8,
    parameter int SIGNED     = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        valor_in,
    output logic [4*OUT_DIGITS-1:0] bcd,
    output logic                    neg,
    output logic                    ovf,
    output logic [OUT_DIGITS-1:0]   blank,
    output logic                    busy,
    output logic                    done
);

    localparam int BCD_W = 4 * INT_DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [OUT_DIGITS-1:0] BLANK_RST = {{(OUT_DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Double-dabble correction: any digit >= 5 would carry past 9 after doubling.
    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int d = 0; d < INT_DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    // Any nonzero digit above the displayed range means the value cannot be shown.
    function automatic logic calc_ovf(input logic [BCD_W-1:0] v);
        logic r;
        r = 1'b0;
        for (int d = OUT_DIGITS; d < INT_DIGITS; d++) begin
            r = r | (v[4*d +: 4] != 4'd0);
        end
        return r;
    endfunction

    // Digit i is blanked when it and every higher displayed digit is zero.
    function automatic logic [OUT_DIGITS-1:0] calc_blank(input logic [BCD_W-1:0] v,
                                                         input logic          o);
        logic [OUT_DIGITS-1:0] b;
        logic                  all_zero;
        b        = '0;
        all_zero = 1'b1;
        for (int i = OUT_DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (v[4*i +: 4] == 4'd0);
            b[i]     = all_zero & ~o;
        end
        return b;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        count_r;
    logic [BCD_W-1:0]        bcd_int_r;
    logic [WIDTH-1:0]        mag_r;
    logic                    sign_r;
    logic [BCD_W-1:0]        adj_s;
    logic [BCD_W+WIDTH-1:0]  cat_s;
    logic [WIDTH-1:0]        mag_cap_s;
    logic                    neg_in_s;
    logic                    last_s;
    logic                    busy_nxt_s, done_nxt_s;
    logic [4*OUT_DIGITS-1:0] bcd_r;
    logic                    neg_r, ovf_r, busy_r, done_r;
    logic [OUT_DIGITS-1:0]   blank_r;

    assign neg_in_s  = (SIGNED != 0) && valor_in[WIDTH-1];
    // Negation wraps modulo 2^WIDTH, so the most negative value maps to 2^(WIDTH-1).
    assign mag_cap_s = neg_in_s ? (~valor_in + {{(WIDTH-1){1'b0}}, 1'b1}) : valor_in;
    assign adj_s     = add3_all(bcd_int_r);
    assign cat_s     = {adj_s, mag_r} << 1'b1;
    assign last_s    = (state_r == ST_SHIFT) && (count_r == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
            ST_SHIFT: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b0;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Conversion datapath: capture on accept, one shift-add-3 step per SHIFT cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r   <= '0;
            bcd_int_r <= '0;
            mag_r     <= '0;
            sign_r    <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            count_r   <= '0;
            bcd_int_r <= '0;
            mag_r     <= mag_cap_s;
            sign_r    <= neg_in_s;
        end else if (state_r == ST_SHIFT) begin
            count_r   <= count_r + CNT_W'(1);
            bcd_int_r <= cat_s[BCD_W+WIDTH-1:WIDTH];
            mag_r     <= cat_s[WIDTH-1:0];
        end else begin
            count_r   <= count_r;
            bcd_int_r <= bcd_int_r;
            mag_r     <= mag_r;
            sign_r    <= sign_r;
        end
    end

    // Result registers: loaded only from the final shift so no partial value leaks out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcd_r   <= '0;
            neg_r   <= 1'b0;
            ovf_r   <= 1'b0;
            blank_r <= BLANK_RST;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_nxt_s;
            if (last_s) begin
                bcd_r   <= cat_s[WIDTH +: 4*OUT_DIGITS];
                neg_r   <= sign_r;
                ovf_r   <= calc_ovf(cat_s[BCD_W+WIDTH-1:WIDTH]);
                blank_r <= calc_blank(cat_s[BCD_W+WIDTH-1:WIDTH],
                                      calc_ovf(cat_s[BCD_W+WIDTH-1:WIDTH]));
            end else begin
                bcd_r   <= bcd_r;
                neg_r   <= neg_r;
                ovf_r   <= ovf_r;
                blank_r <= blank_r;
            end
        end
    end

    assign bcd   = bcd_r;
    assign neg   = neg_r;
    assign ovf   = ovf_r;
    assign blank = blank_r;
    assign busy  = busy_r;
    assign done  = done_r;

endmodule
